// File: rtl/disp_bcd_scan_if.sv
// Bus between the BCD scan display block and its user: the slow clock
// input, the count controls, the BCD count and the display pins.
interface disp_bcd_scan_if;
  logic        slow_clk;
  logic        en;
  logic        up;
  logic        clr;
  logic [15:0] count;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output slow_clk, en, up, clr,
    input  count, an, seg, dp
  );

  modport slave (
    input  slow_clk, en, up, clr,
    output count, an, seg, dp
  );
endinterface

// File: rtl/disp_bcd_scan.sv
// Four-digit BCD event counter clocked by edges of an external slow clock,
// with a multiplexed common-anode seven-segment driver (active-low outputs).
// The slow clock is treated purely as data: synchronized, then edge-detected.
module disp_bcd_scan #(
  parameter int REFRESH_BITS = 18
) (
  input  logic             clk,
  input  logic             reset,
  disp_bcd_scan_if.slave   bus
);

  logic                    s1, s2, prev;
  logic                    step;
  logic [15:0]             count_q;
  logic [15:0]             count_inc, count_dec;
  logic                    carry, borrow;
  logic [REFRESH_BITS-1:0] refresh;
  logic [1:0]              sel;
  logic [3:0]              digit;
  logic [3:0]              an_nxt;
  logic [3:0]              an_q;
  logic [6:0]              seg_q;

  // Segment pattern {g..a}, active-low; non-decimal codes blank the digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  assign step = s2 & ~prev;
  assign sel  = refresh[REFRESH_BITS-1 -: 2];

  // Two-flop synchronizer for slow_clk plus a delayed copy for rising-edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= bus.slow_clk;
      s2   <= s1;
      prev <= s2;
    end
  end

  // BCD ripple increment and decrement candidates, digit by digit from the ones.
  always_comb begin
    count_inc = count_q;
    count_dec = count_q;
    carry     = 1'b1;
    borrow    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow              = 1'b0;
        end
      end
    end
  end

  // Count register: clear beats a step; steps while disabled are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 16'h0000;
    end else if (bus.clr) begin
      count_q <= 16'h0000;
    end else if (step && bus.en) begin
      count_q <= bus.up ? count_inc : count_dec;
    end
  end

  // Free-running refresh counter; its top two bits pick the displayed digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh <= '0;
    end else begin
      refresh <= refresh + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
    end
  end

  // Digit mux: choose the nibble and the matching active-low anode.
  always_comb begin
    digit  = count_q[3:0];
    an_nxt = 4'b1110;
    case (sel)
      2'd0: begin digit = count_q[3:0];   an_nxt = 4'b1110; end
      2'd1: begin digit = count_q[7:4];   an_nxt = 4'b1101; end
      2'd2: begin digit = count_q[11:8];  an_nxt = 4'b1011; end
      2'd3: begin digit = count_q[15:12]; an_nxt = 4'b0111; end
      default: ;
    endcase
  end

  // Registered display outputs so the pins change glitch-free on clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q  <= 4'b1111;
      seg_q <= 7'b1111111;
    end else begin
      an_q  <= an_nxt;
      seg_q <= seg_decode(digit);
    end
  end

  assign bus.count = count_q;
  assign bus.an    = an_q;
  assign bus.seg   = seg_q;
  assign bus.dp    = 1'b1;

endmodule
